// File: rtl/spi_slave_core_pkg.sv
// Shared definitions for the SPI target engine.
//   SPI_TRANS_*_BITS : dtb_i word-size codes, common with the SPI master
//   spi_slv_state_e  : target FSM states
//   spi_slv_cfg_t    : per-frame configuration captured at nss fall
//   word_bits()      : dtb code -> word length in bits (8..32)
package spi_slave_core_pkg;

  localparam logic [1:0] SPI_TRANS_8_BITS  = 2'd0;
  localparam logic [1:0] SPI_TRANS_16_BITS = 2'd1;
  localparam logic [1:0] SPI_TRANS_24_BITS = 2'd2;
  localparam logic [1:0] SPI_TRANS_32_BITS = 2'd3;

  typedef enum logic [1:0] {
    SPI_SLV_IDLE,
    SPI_SLV_LOAD,
    SPI_SLV_SHIFT,
    SPI_SLV_DONE
  } spi_slv_state_e;

  typedef struct packed {
    logic       samp_rise;  // 1: sample on rising sck, shift on falling
    logic       lsb;
    logic [1:0] dtb;
  } spi_slv_cfg_t;

  function automatic logic [5:0] word_bits(input logic [1:0] dtb);
    logic [2:0] bytes;
    bytes = {1'b0, dtb} + 3'd1;
    return {bytes, 3'b000};
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchroniser and edge detector for the asynchronous SPI pins.
// Each pin passes SYNC_STAGES flops; one further register on sck/nss gives
// single-cycle rise/fall pulses aligned with the synchronised levels.
// Ports:
//   clk_i, rst_n_i               system clock, async active-low reset
//   spi_sck_i/nss_i/mosi_i       raw pins
//   nss_o, mosi_o                synchronised levels
//   sck_rise_o, sck_fall_o       sck edge pulses
//   nss_rise_o, nss_fall_o       nss edge pulses
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic spi_sck_i,
  input  logic spi_nss_i,
  input  logic spi_mosi_i,
  output logic nss_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic nss_rise_o,
  output logic nss_fall_o
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] nss_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sck_d;
  logic                   nss_d;
  logic                   sck_s;

  // nss resets high (deselected) so leaving reset never fakes a frame start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sr  <= '0;
      nss_sr  <= '1;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
      nss_d   <= 1'b1;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck_i};
      nss_sr  <= {nss_sr[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi_i};
      sck_d   <= sck_s;
      nss_d   <= nss_o;
    end
  end

  assign sck_s      = sck_sr[SYNC_STAGES-1];
  assign nss_o      = nss_sr[SYNC_STAGES-1];
  assign mosi_o     = mosi_sr[SYNC_STAGES-1];
  assign sck_rise_o = sck_s & ~sck_d;
  assign sck_fall_o = ~sck_s & sck_d;
  assign nss_rise_o = nss_o & ~nss_d;
  assign nss_fall_o = ~nss_o & nss_d;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples an external master's sck/nss/mosi on clk_i,
// deserialises mosi into rx words and serialises tx words onto miso.
// CPOL/CPHA modes 0-3, MSB/LSB first, 8/16/24/32-bit words.
// Ports:
//   clk_i, rst_n_i                 system clock, async active-low reset
//   en_i                           core enable
//   cpol_i, cpha_i, lsb_i, dtb_i   frame configuration (latched at nss fall)
//   tx_valid_i/tx_ready_o/tx_data_i  tx fifo pop interface
//   rx_valid_o/rx_ready_i/rx_data_o  rx fifo push interface
//   busy_o, udr_o, ovr_o           status: frame active, underrun, overrun
//   spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o  SPI pins
//   spi_miso_en_o                  miso pad enable (only with SPI_SLV_MISO_OE_EN)
// Build option: define SPI_SLV_MISO_OE_EN to add spi_miso_en_o; miso then
// holds its last bit outside a frame instead of returning to 0.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dtb_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        udr_o,
  output logic        ovr_o,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o
`ifdef SPI_SLV_MISO_OE_EN
  ,
  output logic        spi_miso_en_o
`endif
);

`ifdef SPI_SLV_MISO_OE_EN
  localparam bit IdleMisoZero = 1'b0;
`else
  localparam bit IdleMisoZero = 1'b1;
`endif

  spi_slv_state_e state;
  spi_slv_cfg_t   cfg;
  logic [31:0]    tx_word;
  logic [31:0]    rx_word;
  logic [31:0]    load_word;
  logic [5:0]     bit_cnt;
  logic [5:0]     nbits;
  logic [4:0]     first_idx;
  logic [4:0]     next_idx;
  logic           nss_s;
  logic           mosi_s;
  logic           sck_rise;
  logic           sck_fall;
  logic           nss_rise;
  logic           nss_fall;
  logic           samp_edge;
  logic           shft_edge;
  logic           abort;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .spi_sck_i  (spi_sck_i),
    .spi_nss_i  (spi_nss_i),
    .spi_mosi_i (spi_mosi_i),
    .nss_o      (nss_s),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .nss_rise_o (nss_rise),
    .nss_fall_o (nss_fall)
  );

  assign nbits     = word_bits(cfg.dtb);
  assign samp_edge = cfg.samp_rise ? sck_rise : sck_fall;
  assign shft_edge = cfg.samp_rise ? sck_fall : sck_rise;
  assign load_word = tx_valid_i ? tx_data_i : '0;

  // Bit positions are taken modulo 32, so width-1 for a 32-bit word is 31.
  assign first_idx = cfg.lsb ? 5'd0 : nbits[4:0] - 5'd1;
  assign next_idx  = cfg.lsb ? bit_cnt[4:0] : nbits[4:0] - 5'd1 - bit_cnt[4:0];

  assign busy_o = ~nss_s & en_i;

  // A completed word in DONE survives an nss rise; only en_i kills it there.
  assign abort = (state != SPI_SLV_IDLE) && (!en_i ||
                 (nss_rise && (state == SPI_SLV_LOAD || state == SPI_SLV_SHIFT)));

`ifdef SPI_SLV_MISO_OE_EN
  assign spi_miso_en_o = busy_o;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= SPI_SLV_IDLE;
      cfg        <= '0;
      tx_word    <= '0;
      rx_word    <= '0;
      bit_cnt    <= '0;
      tx_ready_o <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      udr_o      <= 1'b0;
      ovr_o      <= 1'b0;
      spi_miso_o <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      rx_valid_o <= 1'b0;
      udr_o      <= 1'b0;
      ovr_o      <= 1'b0;
      if (abort) begin
        state <= SPI_SLV_IDLE;
        if (IdleMisoZero) spi_miso_o <= 1'b0;
      end else begin
        case (state)
          SPI_SLV_IDLE: begin
            if (IdleMisoZero) spi_miso_o <= 1'b0;
            if (en_i && nss_fall) begin
              cfg   <= '{samp_rise: ~(cpol_i ^ cpha_i), lsb: lsb_i, dtb: dtb_i};
              state <= SPI_SLV_LOAD;
            end
          end
          SPI_SLV_LOAD: begin
            tx_word    <= load_word;
            spi_miso_o <= load_word[first_idx];
            tx_ready_o <= tx_valid_i;
            udr_o      <= ~tx_valid_i;
            rx_word    <= '0;
            bit_cnt    <= '0;
            state      <= SPI_SLV_SHIFT;
          end
          SPI_SLV_SHIFT: begin
            if (samp_edge) begin
              if (cfg.lsb)
                rx_word <= (rx_word >> 1) | ({31'b0, mosi_s} << (nbits - 6'd1));
              else
                rx_word <= {rx_word[30:0], mosi_s};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt + 6'd1 == nbits) state <= SPI_SLV_DONE;
            end else if (shft_edge && bit_cnt != 6'd0) begin
              // A shift edge before this word's first sample is either the
              // cpha=1 leading edge or the trailing edge of the previous word;
              // bit 0 is already on miso from LOAD, so neither advances.
              spi_miso_o <= tx_word[next_idx];
            end
          end
          SPI_SLV_DONE: begin
            if (rx_ready_i) begin
              rx_valid_o <= 1'b1;
              rx_data_o  <= rx_word;
            end else begin
              ovr_o <= 1'b1;
            end
            state <= nss_s ? SPI_SLV_IDLE : SPI_SLV_LOAD;
          end
          default: state <= SPI_SLV_IDLE;
        endcase
      end
    end
  end

endmodule
